// File: rtl/gameplay_pkg.sv
// Shared types and default timing constants for the gameplay input controller.
package gameplay_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_FRAME_CYCLES    = 1_666_667;
  localparam int unsigned DEF_LOCKOUT_FRAMES  = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHARGE  = 2'd1,
    LOCKOUT = 2'd2
  } hit_state_t;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gameplay_input_ctrl_debouncer.sv
// Two-flop synchronizer followed by a counting debounce FSM for one raw button.
module gameplay_input_ctrl_debouncer
  import gameplay_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic level
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sync_s;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d;

  assign sync_s = sync_q[1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      level   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
    end
  end

  // Counter holds the number of consecutive mismatching samples seen so far.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    case (state_q)
      STABLE: begin
        if (sync_s != level) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            level_d = sync_s;
          end else begin
            state_d = COUNTING;
            cnt_d   = CW'(1);
          end
        end
      end
      COUNTING: begin
        if (sync_s == level) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          level_d = sync_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/gameplay_input_ctrl.sv
// Button conditioning, frame tick, new-game pulse and hit charge/lockout FSM.
module gameplay_input_ctrl
  import gameplay_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned FRAME_CYCLES    = DEF_FRAME_CYCLES,
  parameter int unsigned LOCKOUT_FRAMES  = DEF_LOCKOUT_FRAMES
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_hit_in,
  input  logic btn_left_in,
  input  logic btn_right_in,
  input  logic btn_new_in,
  output logic charging_hit,
  output logic camera_pan_left,
  output logic camera_pan_right,
  output logic new_frame,
  output logic new_game
);

  localparam int unsigned FW = cnt_width(FRAME_CYCLES);
  localparam int unsigned LW = cnt_width(LOCKOUT_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

  logic db_hit, db_left, db_right, db_new;
  logic db_hit_q, db_new_q;
  logic new_game_c;

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          new_frame_d;

  hit_state_t    state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          charging_d;

  gameplay_input_ctrl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hit (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(btn_hit_in), .level(db_hit)
  );
  gameplay_input_ctrl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(btn_left_in), .level(db_left)
  );
  gameplay_input_ctrl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(btn_right_in), .level(db_right)
  );
  gameplay_input_ctrl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_new (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(btn_new_in), .level(db_new)
  );

  assign new_game_c = db_new & ~db_new_q;

  // Frame counter; a new game restarts the frame grid.
  always_comb begin
    frame_cnt_d = frame_cnt_q + FW'(1);
    if (new_game_c || (frame_cnt_q == FRAME_LAST)) begin
      frame_cnt_d = '0;
    end
    new_frame_d = (frame_cnt_d == FRAME_LAST);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      lock_q      <= '0;
      frame_cnt_q <= '0;
      db_hit_q    <= 1'b0;
      db_new_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      frame_cnt_q <= frame_cnt_d;
      db_hit_q    <= db_hit;
      db_new_q    <= db_new;
    end
  end

  // Hit FSM: entry needs a fresh press edge, so a button held through lockout is ignored.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (db_hit && !db_hit_q) begin
          state_d = CHARGE;
        end
      end
      CHARGE: begin
        if (!db_hit) begin
          state_d = LOCKOUT;
          lock_d  = LW'(LOCKOUT_FRAMES);
        end
      end
      LOCKOUT: begin
        if (lock_q == '0) begin
          state_d = IDLE;
        end else if (new_frame) begin
          lock_d = lock_q - LW'(1);
          if (lock_q == LW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        lock_d  = '0;
      end
    endcase
    if (new_game_c) begin
      state_d = IDLE;
      lock_d  = '0;
    end
    charging_d = (state_d == CHARGE);
  end

  // new_game resets high so gameplay sees it on the first edge after reset release.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      charging_hit     <= 1'b0;
      camera_pan_left  <= 1'b0;
      camera_pan_right <= 1'b0;
      new_frame        <= 1'b0;
      new_game         <= 1'b1;
    end else begin
      charging_hit     <= charging_d;
      camera_pan_left  <= db_left & ~db_right;
      camera_pan_right <= db_right & ~db_left;
      new_frame        <= new_frame_d;
      new_game         <= new_game_c;
    end
  end

endmodule

// File: tb/tb_gameplay_input_ctrl.sv
// Directed bench for gameplay_input_ctrl with short debounce, frame and lockout settings.
module tb_gameplay_input_ctrl;

  logic clk_in = 1'b0;
  logic rst_in;
  logic btn_hit_in, btn_left_in, btn_right_in, btn_new_in;
  logic charging_hit, camera_pan_left, camera_pan_right, new_frame, new_game;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int r, lk, m1, m2, s, g;

  always #5 clk_in = ~clk_in;

  gameplay_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .FRAME_CYCLES(10),
    .LOCKOUT_FRAMES(2)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .btn_hit_in(btn_hit_in),
    .btn_left_in(btn_left_in),
    .btn_right_in(btn_right_in),
    .btn_new_in(btn_new_in),
    .charging_hit(charging_hit),
    .camera_pan_left(camera_pan_left),
    .camera_pan_right(camera_pan_right),
    .new_frame(new_frame),
    .new_game(new_game)
  );

  task automatic tick();
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    btn_hit_in = 1'b0; btn_left_in = 1'b0; btn_right_in = 1'b0; btn_new_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_charging", charging_hit, 1'b0);
    chk("rst_pan_left", camera_pan_left, 1'b0);
    chk("rst_pan_right", camera_pan_right, 1'b0);
    chk("rst_new_frame", new_frame, 1'b0);
    chk("rst_new_game", new_game, 1'b1);

    // Release reset; cyc counts rising edges since release.
    rst_in = 1'b1;
    cyc = 0;
    #1 chk("rel_new_game_hi", new_game, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("frame_tick", new_frame, ((cyc % 10) == 9) ? 1'b1 : 1'b0);
      if (k == 1) chk("rel_new_game_lo", new_game, 1'b0);
    end

    // Both pan buttons held cancel each other.
    btn_left_in = 1'b1; btn_right_in = 1'b1;
    repeat (10) tick();
    chk("both_pan_left", camera_pan_left, 1'b0);
    chk("both_pan_right", camera_pan_right, 1'b0);
    btn_right_in = 1'b0;
    repeat (6) tick();
    chk("pan_left_early", camera_pan_left, 1'b0);
    tick();
    chk("pan_left_on", camera_pan_left, 1'b1);
    btn_left_in = 1'b0; btn_right_in = 1'b1;
    repeat (6) tick();
    chk("pan_swap_early_l", camera_pan_left, 1'b1);
    chk("pan_swap_early_r", camera_pan_right, 1'b0);
    tick();
    chk("pan_swap_l", camera_pan_left, 1'b0);
    chk("pan_swap_r", camera_pan_right, 1'b1);
    btn_right_in = 1'b0;
    repeat (10) tick();
    chk("pan_idle_r", camera_pan_right, 1'b0);

    // Bouncing hit press 1-0-1 with 2-cycle widths, then steady.
    btn_hit_in = 1'b1;
    repeat (2) begin tick(); chk("bounce_hi", charging_hit, 1'b0); end
    btn_hit_in = 1'b0;
    repeat (2) begin tick(); chk("bounce_lo", charging_hit, 1'b0); end
    btn_hit_in = 1'b1;
    repeat (6) begin tick(); chk("charge_latency", charging_hit, 1'b0); end
    tick();
    chk("charge_rise", charging_hit, 1'b1);
    repeat (13) tick();
    chk("charge_held", charging_hit, 1'b1);

    // Lockout length: a fresh edge one cycle too early is ignored, on time it charges.
    for (int it = 0; it < 2; it++) begin
      r = cyc;
      btn_hit_in = 1'b0;
      repeat (6) begin tick(); chk("release_latency", charging_hit, 1'b1); end
      tick();
      chk("release_drop", charging_hit, 1'b0);
      lk = r + 7;
      m1 = lk + (9 - (lk % 10));
      m2 = m1 + 10;
      s  = m2 - 6 + it;
      while (cyc < s) begin tick(); chk("lockout_hold", charging_hit, 1'b0); end
      btn_hit_in = 1'b1;
      repeat (6) begin tick(); chk("lockout_press", charging_hit, 1'b0); end
      tick();
      chk(it == 0 ? "lockout_early_edge" : "lockout_exit_edge", charging_hit, it == 1);
      if (it == 0) begin
        repeat (4) begin tick(); chk("held_no_charge", charging_hit, 1'b0); end
        btn_hit_in = 1'b0;
        repeat (10) begin tick(); chk("idle_release", charging_hit, 1'b0); end
        btn_hit_in = 1'b1;
        repeat (6) tick();
        chk("repress_early", charging_hit, 1'b0);
        tick();
        chk("repress_charge", charging_hit, 1'b1);
      end
    end

    // New game during charge; align so the restarted frame grid differs from the old one.
    while ((cyc % 10) != 5) tick();
    btn_new_in = 1'b1;
    repeat (6) tick();
    chk("ng_pre_pulse", new_game, 1'b0);
    chk("ng_pre_charging", charging_hit, 1'b1);
    tick();
    g = cyc;
    chk("ng_pulse", new_game, 1'b1);
    chk("ng_charge_drop", charging_hit, 1'b0);
    tick();
    chk("ng_one_cycle", new_game, 1'b0);
    chk("ng_no_recharge", charging_hit, 1'b0);
    while (cyc < g + 8) tick();
    chk("ng_frame_before", new_frame, 1'b0);
    tick();
    chk("ng_frame_restart", new_frame, 1'b1);
    chk("ng_held_no_repulse", new_game, 1'b0);
    tick();
    chk("ng_frame_after", new_frame, 1'b0);

    // Recharge, then assert reset mid-charge.
    btn_hit_in = 1'b0; btn_new_in = 1'b0;
    repeat (12) tick();
    btn_hit_in = 1'b1;
    repeat (7) tick();
    chk("pre_reset_charge", charging_hit, 1'b1);
    #2 rst_in = 1'b0;
    #1;
    chk("async_rst_charging", charging_hit, 1'b0);
    chk("async_rst_new_game", new_game, 1'b1);
    tick();
    chk("rst_low_new_game", new_game, 1'b1);
    chk("rst_low_charging", charging_hit, 1'b0);
    rst_in = 1'b1;
    btn_hit_in = 1'b0;
    tick();
    chk("post_rst_new_game", new_game, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gameplay_input_ctrl.md
GAMEPLAY_INPUT_CTRL -- requirements
Module: gameplay_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000; consecutive stable cycles required to accept a button change (10 ms at 100 MHz).
REQ-002 Parameter FRAME_CYCLES, default 1_666_667; new_frame period in clocks (60 Hz at 100 MHz).
REQ-003 Parameter LOCKOUT_FRAMES, default 30; frames charging_hit is held off after a hit release.
REQ-004 clk_in  input  1  system clock; the only clock.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 btn_hit_in  input  1  raw asynchronous hit button, active-high.
REQ-007 btn_left_in  input  1  raw pan-left button, active-high.
REQ-008 btn_right_in  input  1  raw pan-right button, active-high.
REQ-009 btn_new_in  input  1  raw new-game button, active-high.
REQ-010 charging_hit  output  1  level; hit being charged; goes to gameplay.
REQ-011 camera_pan_left  output  1  level; pan-left request.
REQ-012 camera_pan_right  output  1  level; pan-right request.
REQ-013 new_frame  output  1  one-cycle pulse per frame.
REQ-014 new_game  output  1  one-cycle synchronous reset pulse for gameplay.

Function
REQ-015 Each raw button SHALL pass a 2-flop synchronizer; all downstream logic uses synchronized values only.
REQ-016 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching sample clears the counter.
REQ-017 Debouncer FSM: STABLE (counter 0) -> COUNTING on mismatch; COUNTING -> STABLE on match (level unchanged) or on count reaching DEBOUNCE_CYCLES-1 (level toggled that cycle).
REQ-018 Frame counter SHALL count 0..FRAME_CYCLES-1 then wrap to 0; new_frame SHALL be 1 exactly in the cycle the counter equals FRAME_CYCLES-1.
REQ-019 new_game SHALL pulse for one cycle on a rising edge of debounced btn_new; the same cycle SHALL reset the frame counter to 0 and the hit FSM to IDLE.
REQ-020 camera_pan_left = debounced left AND NOT debounced right; camera_pan_right symmetric; both pressed -> both 0.
REQ-021 Hit FSM states IDLE, CHARGE, LOCKOUT; charging_hit = 1 only in CHARGE.
REQ-022 IDLE -> CHARGE when debounced hit is 1; a hit already held when entering IDLE SHALL NOT start CHARGE until it is released and re-pressed (edge-triggered entry).
REQ-023 CHARGE -> LOCKOUT when debounced hit falls; lockout frame counter loaded with LOCKOUT_FRAMES.
REQ-024 LOCKOUT decrements the lockout counter on each new_frame; -> IDLE when it reaches 0 on a new_frame; button presses during LOCKOUT are ignored.
REQ-025 Simultaneous new_game and any hit FSM transition: new_game wins (IDLE).
REQ-026 LOCKOUT_FRAMES = 0 SHALL give LOCKOUT -> IDLE on the next clock.
REQ-027 All counters SHALL be sized by $clog2 of their parameter; no counter overflows or wraps except the frame counter.

Reset
REQ-028 While rst_in = 0: synchronizers, debounced levels and counters 0; hit FSM IDLE; charging_hit, camera_pan_left, camera_pan_right, new_frame 0; new_game 1.
REQ-029 new_game SHALL remain 1 for exactly the first rising clk_in after rst_in deasserts, then 0, so gameplay starts from a known state.
REQ-030 Reset asserted mid-charge SHALL drop charging_hit asynchronously and within the same cycle.

Structure
REQ-031 Hit FSM state enum and default parameter constants SHALL live in shared package gameplay_pkg.
REQ-032 Sub-module debouncer (synchronizer + debounce FSM, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times.
REQ-033 All outputs SHALL be registered.

Verification (DEBOUNCE_CYCLES=4, FRAME_CYCLES=10, LOCKOUT_FRAMES=2)
REQ-034 Release reset -> new_game 1 for one cycle; new_frame first pulse 10 cycles after counter starts, then every 10 cycles.
REQ-035 btn_hit bounces 1-0-1 with 2-cycle widths then holds 1 -> charging_hit rises exactly 2+4+1 cycles after steady 1 (sync + debounce + register), never during bounce.
REQ-036 Hit press 20 cycles, release, re-press immediately -> charging_hit 0 until two new_frame pulses pass after release, then rises only after release-and-re-press.
REQ-037 btn_left and btn_right both held -> both pan outputs 0; release right -> camera_pan_left 1 after debounce latency.
REQ-038 btn_new pressed during CHARGE -> one-cycle new_game, charging_hit 0 next cycle, frame counter restarts at 0.
REQ-039 rst_in pulled low mid-CHARGE -> charging_hit 0 immediately, new_game 1 while low.
